// File: rtl/inst_decode_pkg.sv
// rtl/inst_decode_pkg.sv - opcode/funct constants and control encodings for instruction decode
package inst_decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_IN    = 6'h1C;
    localparam logic [5:0] OP_OUT   = 6'h1D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        SRC_OP2  = 2'b00,
        SRC_SEXT = 2'b01,
        SRC_ZEXT = 2'b10
    } alu_srcs_e;

    typedef enum logic [1:0] {
        DST_RT  = 2'b00,
        DST_RD  = 2'b01,
        DST_R31 = 2'b10
    } reg_dist_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JUMP = 2'b11
    } branch_e;

    typedef struct packed {
        logic        reg_write;
        mem_to_reg_e mem_to_reg;
        alu_srcs_e   alu_srcs;
        logic        alu_srcs2;
        alu_op_e     alu_op;
        reg_dist_e   reg_dist;
        branch_e     branch;
        logic        mem_write;
        logic        mem_read;
        logic        uart_to_reg;
        logic        reg_to_uart;
    } ctrl_t;

endpackage

// File: rtl/inst_decode_reg_file.sv
// rtl/inst_decode_reg_file.sv - 32x32 register file, two read ports, write-through bypass, r0 fixed at zero
module reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];
    logic        wr_hit;

    assign wr_hit = we && (waddr != 5'd0);

    // Storage: reset clears everything; r0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_hit) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: same-edge write data wins so the decoder sees the newest value
    always_comb begin
        rdata1 = 32'd0;
        rdata2 = 32'd0;
        if (raddr1 != 5'd0) begin
            rdata1 = (wr_hit && waddr == raddr1) ? wdata : regs[raddr1];
        end
        if (raddr2 != 5'd0) begin
            rdata2 = (wr_hit && waddr == raddr2) ? wdata : regs[raddr2];
        end
    end

endmodule

// File: rtl/inst_decode.sv
// rtl/inst_decode.sv - registered instruction decode stage with register file reads
module inst_decode
    import inst_decode_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               inst,
    input  logic [INST_MEM_WIDTH-1:0] pc,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    input  logic                      RegWrite_before,
    input  logic                      UART_write_enable,
    input  logic [31:0]               data,
    input  logic [4:0]                address,
    output logic                      RegWrite,
    output logic [1:0]                MemtoReg,
    output logic [1:0]                ALUSrcs,
    output logic                      ALUSrcs2,
    output logic [3:0]                ALUOp,
    output logic [1:0]                RegDist,
    output logic [1:0]                Branch,
    output logic                      MemWrite,
    output logic                      MemRead,
    output logic                      UARTtoReg,
    output logic                      RegtoUART,
    output logic [31:0]               op1,
    output logic [31:0]               op2,
    output logic [4:0]                rt,
    output logic [4:0]                rd,
    output logic [4:0]                sa,
    output logic [15:0]               immediate,
    output logic [25:0]               inst_index,
    output logic [INST_MEM_WIDTH-1:0] pc_next,
    output logic [INST_MEM_WIDTH-1:0] pc1_next
);

    ctrl_t       ctrl;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];

    reg_file u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .we     (RegWrite_before | UART_write_enable),
        .waddr  (address),
        .wdata  (data),
        .raddr1 (inst[25:21]),
        .raddr2 (inst[20:16]),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // Control decode: anything not recognised stays all-zero (NOP)
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_dist  = DST_RD;
                        ctrl.alu_srcs  = SRC_OP2;
                        case (funct)
                            FN_SUB:  ctrl.alu_op = ALU_SUB;
                            FN_AND:  ctrl.alu_op = ALU_AND;
                            FN_OR:   ctrl.alu_op = ALU_OR;
                            FN_SLT:  ctrl.alu_op = ALU_SLT;
                            FN_SLL:  ctrl.alu_op = ALU_SLL;
                            FN_SRL:  ctrl.alu_op = ALU_SRL;
                            default: ctrl.alu_op = ALU_ADD;
                        endcase
                        ctrl.alu_srcs2 = (funct == FN_SLL) || (funct == FN_SRL);
                    end
                    FN_JR:   ctrl.branch = BR_JUMP;
                    default: ctrl = '0;
                endcase
            end
            OP_ADDI: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_srcs  = SRC_SEXT;
                ctrl.reg_write = 1'b1;
            end
            OP_ORI: begin
                ctrl.alu_op    = ALU_OR;
                ctrl.alu_srcs  = SRC_ZEXT;
                ctrl.reg_write = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu_op    = ALU_LUI;
                ctrl.alu_srcs  = SRC_ZEXT;
                ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_srcs   = SRC_SEXT;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = WB_MEM;
                ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_srcs  = SRC_SEXT;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = BR_BEQ;
            end
            OP_BNE: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = BR_BNE;
            end
            OP_J:    ctrl.branch = BR_JUMP;
            OP_JAL: begin
                ctrl.branch     = BR_JUMP;
                ctrl.reg_dist   = DST_R31;
                ctrl.mem_to_reg = WB_LINK;
                ctrl.reg_write  = 1'b1;
            end
            OP_IN: begin
                ctrl.uart_to_reg = 1'b1;
                ctrl.reg_write   = 1'b1;
            end
            OP_OUT:  ctrl.reg_to_uart = 1'b1;
            default: ctrl = '0;
        endcase
    end

    // Output register: one-cycle latency for every output, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite   <= 1'b0;
            MemtoReg   <= 2'b00;
            ALUSrcs    <= 2'b00;
            ALUSrcs2   <= 1'b0;
            ALUOp      <= 4'd0;
            RegDist    <= 2'b00;
            Branch     <= 2'b00;
            MemWrite   <= 1'b0;
            MemRead    <= 1'b0;
            UARTtoReg  <= 1'b0;
            RegtoUART  <= 1'b0;
            op1        <= 32'd0;
            op2        <= 32'd0;
            rt         <= 5'd0;
            rd         <= 5'd0;
            sa         <= 5'd0;
            immediate  <= 16'd0;
            inst_index <= 26'd0;
            pc_next    <= '0;
            pc1_next   <= '0;
        end else begin
            RegWrite   <= ctrl.reg_write;
            MemtoReg   <= ctrl.mem_to_reg;
            ALUSrcs    <= ctrl.alu_srcs;
            ALUSrcs2   <= ctrl.alu_srcs2;
            ALUOp      <= ctrl.alu_op;
            RegDist    <= ctrl.reg_dist;
            Branch     <= ctrl.branch;
            MemWrite   <= ctrl.mem_write;
            MemRead    <= ctrl.mem_read;
            UARTtoReg  <= ctrl.uart_to_reg;
            RegtoUART  <= ctrl.reg_to_uart;
            op1        <= rf_rdata1;
            op2        <= rf_rdata2;
            rt         <= inst[20:16];
            rd         <= inst[15:11];
            sa         <= inst[10:6];
            immediate  <= inst[15:0];
            inst_index <= inst[25:0];
            pc_next    <= pc;
            pc1_next   <= pc1;
        end
    end

endmodule

// File: tb/tb_inst_decode.sv
// tb/tb_inst_decode.sv - scoreboard bench for inst_decode with a behavioural reference model
module tb_inst_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic [1:0]  pc, pc1;
    logic        RegWrite_before, UART_write_enable;
    logic [31:0] data;
    logic [4:0]  address;
    logic        RegWrite, ALUSrcs2, MemWrite, MemRead, UARTtoReg, RegtoUART;
    logic [1:0]  MemtoReg, ALUSrcs, RegDist, Branch;
    logic [3:0]  ALUOp;
    logic [31:0] op1, op2;
    logic [4:0]  rt, rd, sa;
    logic [15:0] immediate;
    logic [25:0] inst_index;
    logic [1:0]  pc_next, pc1_next;

    always #5 clk = ~clk;

    inst_decode #(.INST_MEM_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .inst(inst), .pc(pc), .pc1(pc1),
        .RegWrite_before(RegWrite_before), .UART_write_enable(UART_write_enable),
        .data(data), .address(address),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcs(ALUSrcs), .ALUSrcs2(ALUSrcs2),
        .ALUOp(ALUOp), .RegDist(RegDist), .Branch(Branch), .MemWrite(MemWrite),
        .MemRead(MemRead), .UARTtoReg(UARTtoReg), .RegtoUART(RegtoUART),
        .op1(op1), .op2(op2), .rt(rt), .rd(rd), .sa(sa), .immediate(immediate),
        .inst_index(inst_index), .pc_next(pc_next), .pc1_next(pc1_next)
    );

    typedef struct {
        logic [17:0] ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [56:0] fields;
        logic [3:0]  pcs;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_regs [32];
    int          checks   = 0;
    int          failures = 0;
    bit          done     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Control word order: RegWrite MemtoReg ALUSrcs ALUSrcs2 ALUOp RegDist Branch MemWrite MemRead UARTtoReg RegtoUART
    function automatic logic [17:0] ref_ctrl(input logic [31:0] i);
        logic       rw = 0, as2 = 0, mw = 0, mr = 0, u2r = 0, r2u = 0;
        logic [1:0] wb = 0, src = 0, dst = 0, br = 0;
        logic [3:0] aop = 0;
        case (i[31:26])
            6'h00: begin
                if (i[5:0] == 6'h08) br = 2'b11;
                else begin
                    rw = 1; dst = 2'b01;
                    case (i[5:0])
                        6'h20: aop = 0;
                        6'h22: aop = 1;
                        6'h24: aop = 2;
                        6'h25: aop = 3;
                        6'h2A: aop = 4;
                        6'h00: begin aop = 5; as2 = 1; end
                        6'h02: begin aop = 6; as2 = 1; end
                        default: begin rw = 0; dst = 0; end
                    endcase
                end
            end
            6'h08: begin aop = 0; src = 2'b01; rw = 1; end
            6'h0D: begin aop = 3; src = 2'b10; rw = 1; end
            6'h0F: begin aop = 7; src = 2'b10; rw = 1; end
            6'h23: begin src = 2'b01; mr = 1; wb = 2'b01; rw = 1; end
            6'h2B: begin src = 2'b01; mw = 1; end
            6'h04: begin aop = 1; br = 2'b01; end
            6'h05: begin aop = 1; br = 2'b10; end
            6'h02: br = 2'b11;
            6'h03: begin br = 2'b11; dst = 2'b10; wb = 2'b10; rw = 1; end
            6'h1C: begin u2r = 1; rw = 1; end
            6'h1D: r2u = 1;
            default: ;
        endcase
        return {rw, wb, src, as2, aop, dst, br, mw, mr, u2r, r2u};
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return model_regs[a];
    endfunction

    task automatic drive(input logic rst, input logic [31:0] i, input logic [1:0] p, input logic [1:0] p1,
                         input logic rwb, input logic uwe, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        logic we;
        @(negedge clk);
        reset = rst; inst = i; pc = p; pc1 = p1;
        RegWrite_before = rwb; UART_write_enable = uwe; address = a; data = d;
        we = (rwb | uwe) && !rst;
        if (rst) begin
            e = '{ctrl: '0, op1: '0, op2: '0, fields: '0, pcs: '0};
            for (int k = 0; k < 32; k++) model_regs[k] = 32'd0;
        end else begin
            e.ctrl   = ref_ctrl(i);
            e.op1    = ref_read(i[25:21], we, a, d);
            e.op2    = ref_read(i[20:16], we, a, d);
            e.fields = {i[20:16], i[15:11], i[10:6], i[15:0], i[25:0]};
            e.pcs    = {p, p1};
            if (we && a != 0) model_regs[a] = d;
        end
        sb_q.push_back(e);
    endtask

    // Monitor: every edge after stimulus yields one registered result to compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ctrl", 64'({RegWrite, MemtoReg, ALUSrcs, ALUSrcs2, ALUOp, RegDist, Branch,
                                  MemWrite, MemRead, UARTtoReg, RegtoUART}), 64'(e.ctrl));
                check("op1", 64'(op1), 64'(e.op1));
                check("op2", 64'(op2), 64'(e.op2));
                check("fields", 64'({rt, rd, sa, immediate, inst_index}), 64'(e.fields));
                check("pc", 64'({pc_next, pc1_next}), 64'(e.pcs));
            end
        end
    end

    logic [5:0] op_tab [13] = '{6'h00, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05,
                                6'h02, 6'h03, 6'h1C, 6'h1D, 6'h3F};
    logic [5:0] fn_tab [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08, 6'h3F};

    initial begin
        logic [31:0] ri;
        reset = 1; inst = 0; pc = 0; pc1 = 0; RegWrite_before = 0; UART_write_enable = 0;
        address = 0; data = 0;
        for (int k = 0; k < 32; k++) model_regs[k] = 32'd0;

        drive(1, 32'h0, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h0, 0, 0, 0, 0, 0, 0);
        drive(0, 32'h00430820, 1, 1, 0, 0, 0, 0);
        drive(0, 32'h0, 0, 0, 1, 0, 5'd1, 32'h10101010);
        drive(0, 32'h00220820, 0, 0, 0, 0, 0, 0);
        drive(0, 32'h00a62022, 2, 3, 1, 0, 5'd5, 32'hDEADBEEF);
        drive(0, 32'h0, 0, 0, 1, 0, 5'd0, 32'hFFFFFFFF);
        drive(0, 32'h00000820, 0, 0, 0, 0, 0, 0);
        drive(0, 32'h8C410004, 1, 2, 0, 0, 0, 0);
        drive(0, 32'hFC000000, 3, 0, 0, 0, 0, 0);
        drive(0, 32'h0, 0, 0, 0, 1, 5'd7, 32'h77777777);
        drive(0, 32'h00E00820, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h00E00820, 1, 1, 1, 0, 5'd7, 32'hAAAA5555);
        drive(0, 32'h00E70820, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            ri = $urandom;
            ri[31:26] = op_tab[$urandom_range(0, 12)];
            if ($urandom_range(0, 3) != 0) ri[5:0] = fn_tab[$urandom_range(0, 8)];
            ri[25:21] = 5'($urandom_range(0, 7));
            ri[20:16] = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 39) == 0, ri, 2'($urandom), 2'($urandom),
                  1'($urandom), $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom);
        end

        @(negedge clk);
        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", 64'(sb_q.size()), 64'd0);
        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout actual=running required=finished");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/inst_decode.md
INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 Parameter INST_MEM_WIDTH, default 2, width of pc, pc1, pc_next and pc1_next.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 inst  in  32  instruction word, MIPS field layout.
REQ-005 pc / pc1  in  INST_MEM_WIDTH each  current PC / PC+1.
REQ-006 RegWrite_before  in  1  writeback enable from the later stage.
REQ-007 UART_write_enable  in  1  writeback enable for UART-sourced data.
REQ-008 data  in  32  writeback data.
REQ-009 address  in  5  writeback register number.
REQ-010 RegWrite  out  1  instruction writes a register.
REQ-011 MemtoReg  out  2  writeback source: 00 ALU, 01 memory, 10 pc1 (link).
REQ-012 ALUSrcs  out  2  ALU operand B: 00 op2, 01 sign-extended imm, 10 zero-extended imm.
REQ-013 ALUSrcs2  out  1  1 = shift amount taken from sa.
REQ-014 ALUOp  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 LUI.
REQ-015 RegDist  out  2  destination: 00 rt, 01 rd, 10 r31.
REQ-016 Branch  out  2  00 none, 01 BEQ, 10 BNE, 11 jump.
REQ-017 MemWrite / MemRead  out  1 each  data-memory store / load.
REQ-018 UARTtoReg / RegtoUART  out  1 each  UART receive into rt / transmit op1.
REQ-019 op1 / op2  out  32 each  register-file values of rs / rt.
REQ-020 rt, rd, sa  out  5 each; immediate  out  16; inst_index  out  26; raw instruction fields.
REQ-021 pc_next / pc1_next  out  INST_MEM_WIDTH each  pc / pc1 forwarded.

Function
REQ-022 All outputs are registered: values derived from inputs at edge N appear after edge N (one-cycle latency), with no handshake.
REQ-023 Register file holds 32 x 32-bit registers; r0 reads 0 and is never written.
REQ-024 Write occurs at the clock edge when (RegWrite_before | UART_write_enable) and address != 0, storing data at address.
REQ-025 Read of an address written on the same edge returns the new data (write-through bypass).
REQ-026 Opcode 0x00 funct decode: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (RegDist 01, ALUSrcs 00, RegWrite 1); SLL 0x00, SRL 0x02 (additionally ALUSrcs2 1); JR 0x08 (Branch 11, RegWrite 0).
REQ-027 I-type: ADDI 0x08 (ADD, ALUSrcs 01); ORI 0x0D (OR, ALUSrcs 10); LUI 0x0F (ALUOp 7, ALUSrcs 10); all three use RegDist 00, RegWrite 1.
REQ-028 LW 0x23: ADD, ALUSrcs 01, MemRead 1, MemtoReg 01, RegWrite 1. SW 0x2B: ADD, ALUSrcs 01, MemWrite 1, RegWrite 0.
REQ-029 BEQ 0x04 and BNE 0x05: SUB, ALUSrcs 00, Branch 01 / 10. J 0x02: Branch 11. JAL 0x03: Branch 11, RegDist 10, MemtoReg 10, RegWrite 1.
REQ-030 IN 0x1C: UARTtoReg 1, RegWrite 1, RegDist 00. OUT 0x1D: RegtoUART 1.
REQ-031 Any undefined opcode or funct drives all control outputs to 0 (NOP); field outputs still carry inst bits.
REQ-032 Field mapping: rs = inst[25:21], rt = inst[20:16], rd = inst[15:11], sa = inst[10:6], immediate = inst[15:0], inst_index = inst[25:0].

Reset
REQ-033 While reset is high at a clock edge, every output becomes 0, all registers clear to 0, and no write occurs.
REQ-034 Reset asserted mid-operation takes priority over a simultaneous writeback.

Structure
REQ-035 A shared package holds the opcode and funct constants and the ALUOp, MemtoReg, RegDist, Branch and ALUSrcs encodings.
REQ-036 One sub-module, reg_file (two read ports, one write port, bypass, r0 hardwired to zero), is instantiated; decode logic stays in inst_decode.

Verification
REQ-037 Reset, then inst 0x00430820, pc 1, pc1 1 -> ALUOp 0, RegDist 01, RegWrite 1, rt 3, rd 1, op1 0, op2 0, pc_next 1.
REQ-038 RegWrite_before 1, address 1, data 0x10101010 for one edge, then inst 0x00220820 -> op1 0x10101010.
REQ-039 Same-edge write address 5, data 0xDEADBEEF with inst 0x00a62022 -> op1 0xDEADBEEF, ALUOp 1, rd 4.
REQ-040 Write to address 0 with data 0xFFFFFFFF, then read r0 -> op1 0.
REQ-041 inst 0x8C410004 (LW) -> MemRead 1, MemtoReg 01, ALUSrcs 01, immediate 0x0004; inst 0xFC000000 -> all control outputs 0.
REQ-042 Reset asserted with a concurrent write -> outputs 0, register unchanged at 0.
